// File: rtl/subtraction_3072_256.sv
// Multi-limb borrow-select subtractor: c = (a - b) mod 2^SIZE with a final borrow flag.
// Per-limb differences for borrow-in 0 and 1 are precomputed, then a borrow ripple selects between them.
module subtraction_3072_256 #(
   parameter int unsigned LIMB_W = 256,
   parameter int unsigned N_LIMB = 13,
   localparam int unsigned SIZE  = LIMB_W * N_LIMB
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] c,
   output logic            borrow_out,
   output logic            busy,
   output logic            en_out
);

   localparam int unsigned DW = LIMB_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      D0   = 2'd1,
      D1   = 2'd2,
      SEL  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [SIZE-1:0]   r_a;
   logic [SIZE-1:0]   r_b;
   logic [DW-1:0]     r_d0 [N_LIMB];
   logic [DW-1:0]     r_d1 [N_LIMB];
   logic [SIZE-1:0]   r_c;
   logic              r_borrow;
   logic              r_busy;
   logic              r_en_out;

   logic              w_load;
   logic              w_calc_d0;
   logic              w_calc_d1;
   logic              w_commit;
   logic              w_busy_next;
   logic [SIZE-1:0]   w_diff;
   logic              w_borrow;
   logic [DW-1:0]     w_sel [N_LIMB];

   // Next-state and control strobes
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_calc_d0    = 1'b0;
      w_calc_d1    = 1'b0;
      w_commit     = 1'b0;
      w_busy_next  = r_busy;
      case (r_state)
         IDLE: begin
            w_busy_next = 1'b0;
            if (en) begin
               w_load       = 1'b1;
               w_busy_next  = 1'b1;
               w_state_next = D0;
            end
         end
         D0: begin
            w_calc_d0    = 1'b1;
            w_busy_next  = 1'b1;
            w_state_next = D1;
         end
         D1: begin
            w_calc_d1    = 1'b1;
            w_busy_next  = 1'b1;
            w_state_next = SEL;
         end
         SEL: begin
            w_commit     = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = IDLE;
         end
         default: begin
            w_busy_next  = 1'b0;
            w_state_next = IDLE;
         end
      endcase
   end

   // Borrow ripple: limb 0 always sees borrow-in 0, so it takes the d0 word
   always_comb begin
      w_borrow = 1'b0;
      w_diff   = '0;
      for (int unsigned i = 0; i < N_LIMB; i++) begin
         w_sel[i] = w_borrow ? r_d1[i] : r_d0[i];
         w_diff[i*LIMB_W +: LIMB_W] = w_sel[i][LIMB_W-1:0];
         w_borrow = w_sel[i][LIMB_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_en_out <= 1'b0;
         for (int unsigned i = 0; i < N_LIMB; i++) begin
            r_d0[i] <= '0;
            r_d1[i] <= '0;
         end
      end else begin
         r_state  <= w_state_next;
         r_busy   <= w_busy_next;
         r_en_out <= w_commit;
         if (w_load) begin
            r_a <= a;
            r_b <= b;
         end
         for (int unsigned i = 0; i < N_LIMB; i++) begin
            if (w_calc_d0)
               r_d0[i] <= {1'b0, r_a[i*LIMB_W +: LIMB_W]} - {1'b0, r_b[i*LIMB_W +: LIMB_W]};
            if (w_calc_d1)
               r_d1[i] <= {1'b0, r_a[i*LIMB_W +: LIMB_W]} - {1'b0, r_b[i*LIMB_W +: LIMB_W]} - DW'(1);
         end
         if (w_commit) begin
            r_c      <= w_diff;
            r_borrow <= w_borrow;
         end
      end
   end

   assign c          = r_c;
   assign borrow_out = r_borrow;
   assign busy       = r_busy;
   assign en_out     = r_en_out;

endmodule

// File: tb/tb_subtraction_3072_256.sv
// Directed-vector bench for subtraction_3072_256: latency, busy window, wrap/borrow cases,
// ignored starts while busy, back-to-back issue and mid-operation reset.
module tb_subtraction_3072_256;

   localparam int unsigned LIMB_W = 256;
   localparam int unsigned N_LIMB = 13;
   localparam int unsigned SIZE   = LIMB_W * N_LIMB;
   localparam int unsigned NWORD  = SIZE / 64;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic [SIZE-1:0] c;
   logic            borrow_out;
   logic            busy;
   logic            en_out;

   int n_checks;
   int n_fail;

   subtraction_3072_256 #(.LIMB_W(LIMB_W), .N_LIMB(N_LIMB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .a          (a),
      .b          (b),
      .c          (c),
      .borrow_out (borrow_out),
      .busy       (busy),
      .en_out     (en_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare and report the first differing 64-bit word on mismatch
   task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
      int w;
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         w = 0;
         for (int k = NWORD - 1; k >= 0; k--)
            if (got[k*64 +: 64] !== exp[k*64 +: 64]) w = k;
         $display("FAIL %s: word %0d got %h expected %h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
      end
   endtask

   // Issue one operation and wait (bounded) for its result
   task automatic do_op(input string tag, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                        input logic [SIZE-1:0] exp_c, input logic exp_bo);
      int cyc;
      int busy_cnt;
      a  = av;
      b  = bv;
      en = 1'b1;
      tick();
      en = 1'b0;
      a  = '0;
      b  = '0;
      cyc      = 0;
      busy_cnt = 0;
      while (!en_out && cyc < 10) begin
         if (busy) busy_cnt++;
         tick();
         cyc++;
      end
      check({tag, "_latency"}, SIZE'(cyc), SIZE'(3));
      check({tag, "_busy_cycles"}, SIZE'(busy_cnt), SIZE'(3));
      check({tag, "_busy_done"}, SIZE'(busy), SIZE'(0));
      check({tag, "_c"}, c, exp_c);
      check({tag, "_borrow"}, SIZE'(borrow_out), SIZE'(exp_bo));
      tick();
      check({tag, "_en_out_pulse"}, SIZE'(en_out), SIZE'(0));
      check({tag, "_c_hold"}, c, exp_c);
   endtask

   initial begin
      logic [SIZE-1:0] va;
      logic [SIZE-1:0] vb;
      logic [SIZE-1:0] ve;
      int seen;

      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      a        = '0;
      b        = '0;
      tick();
      tick();
      check("rst_c", c, '0);
      check("rst_borrow", SIZE'(borrow_out), SIZE'(0));
      check("rst_busy", SIZE'(busy), SIZE'(0));
      check("rst_en_out", SIZE'(en_out), SIZE'(0));
      rst_n = 1'b1;
      tick();

      do_op("5m3", SIZE'(5), SIZE'(3), SIZE'(2), 1'b0);

      do_op("0m1", SIZE'(0), SIZE'(1), '1, 1'b1);

      va = '0;
      va[LIMB_W*12] = 1'b1;
      ve = '0;
      ve[LIMB_W*12-1:0] = '1;
      do_op("ripple", va, SIZE'(1), ve, 1'b0);

      for (int k = 0; k < SIZE / 32; k++) va[k*32 +: 32] = $urandom;
      do_op("equal", va, va, '0, 1'b0);

      do_op("1mmax", SIZE'(1), '1, SIZE'(2), 1'b1);

      // Extra starts during D0 and SEL must be ignored
      a  = SIZE'(10);
      b  = SIZE'(4);
      en = 1'b1;
      tick();
      check("ign_busy_d0", SIZE'(busy), SIZE'(1));
      a = SIZE'(100);
      b = SIZE'(1);
      tick();
      en = 1'b0;
      tick();
      en = 1'b1;
      a  = SIZE'(55);
      b  = SIZE'(77);
      tick();
      check("ign_en_out", SIZE'(en_out), SIZE'(1));
      check("ign_c", c, SIZE'(6));
      check("ign_borrow", SIZE'(borrow_out), SIZE'(0));

      // Back-to-back start on the en_out cycle: 3 - 7 wraps
      a = SIZE'(3);
      b = SIZE'(7);
      tick();
      en = 1'b0;
      check("b2b_accept_busy", SIZE'(busy), SIZE'(1));
      check("b2b_en_out_low", SIZE'(en_out), SIZE'(0));
      tick();
      tick();
      tick();
      ve = '1;
      ve[1:0] = 2'b00;
      check("b2b_en_out", SIZE'(en_out), SIZE'(1));
      check("b2b_c", c, ve);
      check("b2b_borrow", SIZE'(borrow_out), SIZE'(1));
      tick();

      // Reset in D1 aborts the operation and clears the result
      a  = SIZE'(9);
      b  = SIZE'(2);
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", SIZE'(busy), SIZE'(0));
      check("abort_c", c, '0);
      check("abort_borrow", SIZE'(borrow_out), SIZE'(0));
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (en_out) seen++;
         tick();
      end
      check("abort_no_en_out", SIZE'(seen), SIZE'(0));

      do_op("after_abort", SIZE'(9), SIZE'(2), SIZE'(7), 1'b0);

      // Reset wins over a simultaneous start
      rst_n = 1'b0;
      en    = 1'b1;
      a     = SIZE'(8);
      b     = SIZE'(1);
      tick();
      rst_n = 1'b1;
      en    = 1'b0;
      check("rst_vs_en_busy", SIZE'(busy), SIZE'(0));
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (en_out) seen++;
         tick();
      end
      check("rst_vs_en_no_result", SIZE'(seen), SIZE'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/subtraction_3072_256.md
Name: subtraction_3072_256

Overview:
- Multi-limb modular subtractor, the inverse companion of the 13x256-bit carry-select adder in the modular arithmetic datapath.
- Computes c = (a - b) mod 2^(LIMB_W*N_LIMB) and a borrow flag. The flag gives a >= b / a < b for conditional-correction steps.
- Uses borrow-select: per-limb differences are precomputed for borrow-in 0 and borrow-in 1, then a ripple selects between them.
- Operands are captured on acceptance, so the upstream block may change a/b immediately after the handshake.

Parameters:
- LIMB_W, 256, bits per limb
- N_LIMB, 13, number of limbs
- SIZE, LIMB_W*N_LIMB (3328), operand/result width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- en  input  1  start pulse; accepted only when busy=0
- a  input  SIZE  minuend, sampled on the accepting edge
- b  input  SIZE  subtrahend, sampled on the accepting edge
- c  output  SIZE  registered difference; holds until the next result
- borrow_out  output  1  registered final borrow (1 iff a < b); holds with c
- busy  output  1  high while an operation is in flight
- en_out  output  1  one-cycle pulse: c/borrow_out are valid and new

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk. Reset values: c=0, borrow_out=0, en_out=0, busy=0, state=IDLE, all internal registers=0.
- Reset mid-operation: the operation is aborted, no en_out is produced, and c is cleared to 0.
- FSM states: IDLE, D0, D1, SEL.
  - IDLE: if en=1 at an edge, register a_r<=a and b_r<=b; go to D0; busy<=1.
  - D0: for each limb i, d0[i] <= {1'b0,a_r[i]} - {1'b0,b_r[i]} (257 bits, bit 256 = borrow). Go to D1.
  - D1: d1[i] <= {1'b0,a_r[i]} - {1'b0,b_r[i]} - 1. Go to SEL.
  - SEL: combinational borrow ripple.
    - Limb 0 takes d0[0]; its borrow is d0[0][256].
    - Limb i>0 takes d1[i] if the incoming borrow is 1, else d0[i]; its borrow comes from the selected word's bit 256.
    - Register c, borrow_out <= final borrow, en_out<=1, busy<=0; go to IDLE.
- en_out is 1 for exactly one cycle, and is 0 in every state except the cycle after SEL.
- Latency: the en-accept edge is E0; en_out is high in the cycle following edge E0+3.
- Throughput: a new en may be accepted at the edge that ends the en_out cycle, giving one operation per 4 cycles.
- en while busy=1 (D0/D1/SEL) is ignored: no queueing, and operands are not resampled.
- en and rst_n=0 on the same edge: reset wins.
- Width rules:
  - All limb arithmetic is 257-bit unsigned; the result wraps mod 2^SIZE.
  - No sign interpretation.
  - borrow_out is the only indication of underflow.
- c and borrow_out change only on the SEL edge or on reset.

Test Plan:
- a=5, b=3 -> en_out 3 cycles after accept; c=2, borrow_out=0; busy high for exactly 3 cycles.
- a=0, b=1 -> c=all 3328 bits 1, borrow_out=1.
- a=2^(256*12), b=1 -> limbs 0..11 = 2^256-1 and limb 12 = 0, borrow_out=0. This checks the full borrow ripple through d1 selection.
- a=b=random value -> c=0, borrow_out=0. Then a=1, b=2^3328-1 -> c=2, borrow_out=1.
- Pulse en again during D0 and SEL with different operands -> ignored; result matches the first operands. Then back-to-back en at the en_out edge -> accepted, second result 4 cycles later.
- Start an operation, assert rst_n=0 in D1 -> no en_out, c=0, borrow_out=0, busy=0. A new op after release completes correctly.
